window3_s16: RTL and testbench

- Streaming front end for the three-input signed maximum stage.
- Accepts one signed 16-bit sample per handshake and assembles windows of three consecutive samples.
- Presents each window as win_a (oldest), win_b, win_c (newest) with a valid/ready handshake, so the max stage computes the running window maximum.
- Supports sliding (overlapping) and tumbling (non-overlapping) windowing, and counts the windows delivered.

---
 rtl/window3_s16_if.sv | 26 ++
 rtl/window3_s16.sv | 88 ++++++++
 tb/tb_window3_s16.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window3_s16_if.sv
// Sample-in / window-out handshake bundle for the three-sample window front end.
// The slave modport is the window builder; the master modport is the producer/consumer side.
interface window3_s16_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic signed [WIDTH-1:0] in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] win_a;
   logic signed [WIDTH-1:0] win_b;
   logic signed [WIDTH-1:0] win_c;
   logic                    win_valid;
   logic                    win_ready;
   logic [CNT_W-1:0]        win_count;

   modport slave (
      input  in_data, in_valid, win_ready,
      output in_ready, win_a, win_b, win_c, win_valid, win_count
   );

   modport master (
      output in_data, in_valid, win_ready,
      input  in_ready, win_a, win_b, win_c, win_valid, win_count
   );
endinterface

// File: rtl/window3_s16.sv
// Assembles signed samples into three-sample windows (oldest in win_a) for the max stage,
// in sliding or tumbling mode, and counts delivered windows.
//
// state | meaning
// FILL0 | no samples of the current window held
// FILL1 | one sample held
// FILL2 | two samples held
// FULL  | three samples held; win_valid marks an undelivered window
module window3_s16 #(
   parameter int WIDTH = 16,
   parameter int SLIDE = 1,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   window3_s16_if.slave bus
);
   typedef enum logic [1:0] {FILL0, FILL1, FILL2, FULL} state_t;

   state_t                  state;
   logic signed [WIDTH-1:0] a_q, b_q, c_q;
   logic                    valid_q;
   logic [CNT_W-1:0]        count_q;
   logic                    in_ready;
   logic                    accept;
   logic                    out_hs;

   assign in_ready = !valid_q || bus.win_ready;
   assign accept   = bus.in_valid && in_ready;
   assign out_hs   = valid_q && bus.win_ready;

   assign bus.in_ready  = in_ready;
   assign bus.win_a     = a_q;
   assign bus.win_b     = b_q;
   assign bus.win_c     = c_q;
   assign bus.win_valid = valid_q;
   assign bus.win_count = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FILL0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else if (clear) begin
         // window data is left in place; only the bookkeeping is flushed
         state   <= FILL0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         if (out_hs) count_q <= count_q + CNT_W'(1);
         if (accept) begin
            a_q <= b_q;
            b_q <= c_q;
            c_q <= bus.in_data;
         end
         case (state)
            FILL0: if (accept) state <= FILL1;
            FILL1: if (accept) state <= FILL2;
            FILL2: begin
               if (accept) begin
                  state   <= FULL;
                  valid_q <= 1'b1;
               end
            end
            FULL: begin
               if (SLIDE != 0) begin
                  if (accept)      valid_q <= 1'b1;
                  else if (out_hs) valid_q <= 1'b0;
               end else begin
                  // tumbling: an accept here can only ride on a handshake and starts the next window
                  if (accept) begin
                     state   <= FILL1;
                     valid_q <= 1'b0;
                  end else if (out_hs) begin
                     state   <= FILL0;
                     valid_q <= 1'b0;
                  end
               end
            end
            default: state <= FILL0;
         endcase
      end
   end
endmodule

// File: tb/tb_window3_s16.sv
// Bench for window3_s16: directed scenarios plus a randomized run against a window model,
// on a sliding, a tumbling and a narrow-counter instance.
module tb_window3_s16;
   logic clk;
   logic rst_n;
   logic clear;
   logic                iv[3];
   logic signed [15:0]  dd[3];
   logic                wr[3];
   logic signed [15:0]  o_a[3], o_b[3], o_c[3];
   logic                o_v[3], o_r[3];
   logic [15:0]         o_cnt[3];
   int vectors;
   int miscompares;

   window3_s16_if #(.WIDTH(16), .CNT_W(16)) if0 ();
   window3_s16_if #(.WIDTH(16), .CNT_W(16)) if1 ();
   window3_s16_if #(.WIDTH(16), .CNT_W(2))  if2 ();

   window3_s16 #(.WIDTH(16), .SLIDE(1), .CNT_W(16)) u_slide (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0));
   window3_s16 #(.WIDTH(16), .SLIDE(0), .CNT_W(16)) u_tumble (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1));
   window3_s16 #(.WIDTH(16), .SLIDE(1), .CNT_W(2))  u_wrap (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if2));

   assign if0.in_valid = iv[0];  assign if0.in_data = dd[0];  assign if0.win_ready = wr[0];
   assign if1.in_valid = iv[1];  assign if1.in_data = dd[1];  assign if1.win_ready = wr[1];
   assign if2.in_valid = iv[2];  assign if2.in_data = dd[2];  assign if2.win_ready = wr[2];

   assign o_a[0] = if0.win_a;  assign o_b[0] = if0.win_b;  assign o_c[0] = if0.win_c;
   assign o_a[1] = if1.win_a;  assign o_b[1] = if1.win_b;  assign o_c[1] = if1.win_c;
   assign o_a[2] = if2.win_a;  assign o_b[2] = if2.win_b;  assign o_c[2] = if2.win_c;
   assign o_v[0] = if0.win_valid;  assign o_v[1] = if1.win_valid;  assign o_v[2] = if2.win_valid;
   assign o_r[0] = if0.in_ready;   assign o_r[1] = if1.in_ready;   assign o_r[2] = if2.in_ready;
   assign o_cnt[0] = if0.win_count;
   assign o_cnt[1] = if1.win_count;
   assign o_cnt[2] = {14'd0, if2.win_count};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0;
         dd[i] = '0;
         wr[i] = 1'b1;
      end
   endtask

   task automatic do_clear();
      idle_all();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({o_v[i], o_cnt[i], o_a[i], o_b[i], o_c[i]} !== {1'b0, 16'd0, 48'd0}) begin
            miscompares++;
            $display("FAIL reset_state inst%0d: got v=%0b cnt=%0d a=%0d b=%0d c=%0d, want all 0", i, o_v[i], o_cnt[i], o_a[i], o_b[i], o_c[i]);
         end
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (o_r[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %0b want 1", o_r[0]);
      end
   endtask

   task automatic test_fill_and_sliding();
      logic signed [15:0] s[6];
      s = '{16'sd5, -16'sd3, 16'sd7, 16'sd100, -16'sd32768, 16'sd32767};
      iv[0] = 1'b1;
      wr[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         dd[0] = s[k];
         #1;
         vectors++;
         if (o_r[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL slide_in_ready k=%0d: got %0b want 1", k, o_r[0]);
         end
         tick();
         vectors++;
         if (k < 2 && o_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_early_valid k=%0d: got %0b want 0", k, o_v[0]);
         end else if (k >= 2 && {o_v[0], o_a[0], o_b[0], o_c[0], o_cnt[0]} !== {1'b1, s[k-2], s[k-1], s[k], 16'(k-2)}) begin
            miscompares++;
            $display("FAIL slide_window k=%0d: got v=%0b (%0d,%0d,%0d) cnt=%0d want (%0d,%0d,%0d) cnt=%0d",
                     k, o_v[0], o_a[0], o_b[0], o_c[0], o_cnt[0], s[k-2], s[k-1], s[k], k-2);
         end
      end
      iv[0] = 1'b0;
      tick();
      vectors++;
      if ({o_v[0], o_cnt[0]} !== {1'b0, 16'd4}) begin
         miscompares++;
         $display("FAIL slide_drain: got v=%0b cnt=%0d want v=0 cnt=4", o_v[0], o_cnt[0]);
      end
   endtask

   task automatic test_backpressure();
      do_clear();
      wr[0] = 1'b0;
      iv[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         dd[0] = 16'(k);
         tick();
      end
      dd[0] = 16'sd4;
      for (int k = 0; k < 4; k++) begin
         #1;
         vectors++;
         if (o_r[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_in_ready cyc=%0d: got %0b want 0", k, o_r[0]);
         end
         tick();
         vectors++;
         if ({o_v[0], o_a[0], o_b[0], o_c[0], o_cnt[0]} !== {1'b1, 16'sd1, 16'sd2, 16'sd3, 16'd0}) begin
            miscompares++;
            $display("FAIL stall_hold cyc=%0d: got v=%0b (%0d,%0d,%0d) cnt=%0d want (1,2,3) cnt=0", k, o_v[0], o_a[0], o_b[0], o_c[0], o_cnt[0]);
         end
      end
      wr[0] = 1'b1;
      #1;
      vectors++;
      if (o_r[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL release_in_ready: got %0b want 1", o_r[0]);
      end
      tick();
      vectors++;
      if ({o_v[0], o_a[0], o_b[0], o_c[0], o_cnt[0]} !== {1'b1, 16'sd2, 16'sd3, 16'sd4, 16'd1}) begin
         miscompares++;
         $display("FAIL release_window: got v=%0b (%0d,%0d,%0d) cnt=%0d want (2,3,4) cnt=1", o_v[0], o_a[0], o_b[0], o_c[0], o_cnt[0]);
      end
      iv[0] = 1'b0;
      tick();
   endtask

   task automatic test_tumbling();
      do_clear();
      iv[1] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         dd[1] = 16'(k);
         tick();
         vectors++;
         if (k == 3 || k == 6) begin
            if ({o_v[1], o_a[1], o_b[1], o_c[1]} !== {1'b1, 16'(k-2), 16'(k-1), 16'(k)}) begin
               miscompares++;
               $display("FAIL tumble_window k=%0d: got v=%0b (%0d,%0d,%0d) want (%0d,%0d,%0d)", k, o_v[1], o_a[1], o_b[1], o_c[1], k-2, k-1, k);
            end
         end else if (o_v[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL tumble_gap k=%0d: got v=%0b want 0", k, o_v[1]);
         end
      end
      iv[1] = 1'b0;
      tick();
      vectors++;
      if ({o_v[1], o_cnt[1]} !== {1'b0, 16'd2}) begin
         miscompares++;
         $display("FAIL tumble_count: got v=%0b cnt=%0d want v=0 cnt=2", o_v[1], o_cnt[1]);
      end
   endtask

   task automatic test_clear();
      do_clear();
      iv[0] = 1'b1;
      dd[0] = 16'sd10;
      tick();
      dd[0] = 16'sd20;
      tick();
      dd[0] = 16'sd30;
      clear = 1'b1;
      #1;
      vectors++;
      if (o_r[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL clear_in_ready: got %0b want 1", o_r[0]);
      end
      tick();
      clear = 1'b0;
      dd[0] = 16'sd40;
      tick();
      dd[0] = 16'sd50;
      tick();
      vectors++;
      if (o_v[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_dropped: got v=%0b (%0d,%0d,%0d) want v=0", o_v[0], o_a[0], o_b[0], o_c[0]);
      end
      dd[0] = 16'sd60;
      tick();
      vectors++;
      if ({o_v[0], o_a[0], o_b[0], o_c[0], o_cnt[0]} !== {1'b1, 16'sd40, 16'sd50, 16'sd60, 16'd0}) begin
         miscompares++;
         $display("FAIL clear_refill: got v=%0b (%0d,%0d,%0d) cnt=%0d want (40,50,60) cnt=0", o_v[0], o_a[0], o_b[0], o_c[0], o_cnt[0]);
      end
      iv[0] = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      wr[0] = 1'b0;
      iv[0] = 1'b1;
      for (int k = 7; k <= 9; k++) begin
         dd[0] = 16'(k);
         tick();
      end
      iv[0] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_v[0], o_cnt[0], o_a[0], o_r[0]} !== {1'b0, 16'd0, 16'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL async_reset: got v=%0b cnt=%0d a=%0d rdy=%0b want v=0 cnt=0 a=0 rdy=1", o_v[0], o_cnt[0], o_a[0], o_r[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wr[0] = 1'b1;
      iv[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         dd[0] = 16'(k);
         tick();
      end
      vectors++;
      if ({o_v[0], o_a[0], o_b[0], o_c[0]} !== {1'b1, 16'sd1, 16'sd2, 16'sd3}) begin
         miscompares++;
         $display("FAIL reset_refill: got v=%0b (%0d,%0d,%0d) want (1,2,3)", o_v[0], o_a[0], o_b[0], o_c[0]);
      end
      iv[0] = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      do_clear();
      iv[2] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         dd[2] = 16'(k * 11);
         tick();
         if (k >= 4) begin
            vectors++;
            if (o_cnt[2] !== 16'((k - 3) % 4)) begin
               miscompares++;
               $display("FAIL wrap_count k=%0d: got %0d want %0d", k, o_cnt[2], (k - 3) % 4);
            end
         end
      end
      iv[2] = 1'b0;
      tick();
      vectors++;
      if (o_cnt[2] !== 16'd1) begin
         miscompares++;
         $display("FAIL wrap_count_final: got %0d want 1", o_cnt[2]);
      end
   endtask

   task automatic test_random();
      bit                 pend[3];
      int                 nf[3];
      int                 cnt[3];
      logic signed [15:0] h[3][3];
      bit                 acc[3];
      bit                 hs[3];
      bit                 er;
      bit                 slide_m[3];
      int                 msk[3];
      slide_m = '{1'b1, 1'b0, 1'b1};
      msk = '{65535, 65535, 3};
      do_clear();
      for (int i = 0; i < 3; i++) begin
         pend[i] = 1'b0;
         nf[i] = 0;
         cnt[i] = 0;
         for (int j = 0; j < 3; j++) h[i][j] = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         clear = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 3; i++) begin
            iv[i] = ($urandom_range(0, 3) != 0);
            dd[i] = 16'($urandom);
            wr[i] = ($urandom_range(0, 2) != 0);
         end
         #1;
         for (int i = 0; i < 3; i++) begin
            er = !pend[i] || wr[i];
            vectors++;
            if ({o_r[i], o_v[i]} !== {er, pend[i]}) begin
               miscompares++;
               $display("FAIL rand_hs inst%0d cyc=%0d: got rdy=%0b v=%0b want rdy=%0b v=%0b", i, cyc, o_r[i], o_v[i], er, pend[i]);
            end
            vectors++;
            if (o_cnt[i] !== 16'(cnt[i] & msk[i])) begin
               miscompares++;
               $display("FAIL rand_count inst%0d cyc=%0d: got %0d want %0d", i, cyc, o_cnt[i], cnt[i] & msk[i]);
            end
            if (pend[i]) begin
               vectors++;
               if ({o_a[i], o_b[i], o_c[i]} !== {h[i][0], h[i][1], h[i][2]}) begin
                  miscompares++;
                  $display("FAIL rand_window inst%0d cyc=%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                           i, cyc, o_a[i], o_b[i], o_c[i], h[i][0], h[i][1], h[i][2]);
               end
            end
            acc[i] = iv[i] && er && !clear;
            hs[i] = pend[i] && wr[i] && !clear;
         end
         tick();
         for (int i = 0; i < 3; i++) begin
            if (clear) begin
               pend[i] = 1'b0;
               nf[i] = 0;
               cnt[i] = 0;
            end else begin
               if (hs[i]) begin
                  cnt[i]++;
                  pend[i] = 1'b0;
               end
               if (acc[i]) begin
                  h[i][0] = h[i][1];
                  h[i][1] = h[i][2];
                  h[i][2] = dd[i];
                  nf[i]++;
                  if (nf[i] >= 3) begin
                     pend[i] = 1'b1;
                     nf[i] = slide_m[i] ? 3 : 0;
                  end
               end
            end
         end
      end
      clear = 1'b0;
      idle_all();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      clear = 1'b0;
      idle_all();
      test_reset();
      test_fill_and_sliding();
      test_backpressure();
      test_tumbling();
      test_clear();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
